// File: rtl/spi_cmd_ctrl_if.sv
// Byte-stream and memory/tx-control signals between the SPI receiver side and spi_cmd_ctrl.
// The master modport is the stimulus side; spi_cmd_ctrl connects to the slave modport.
interface spi_cmd_ctrl_if #(
    parameter int AddrBits = 12
);
    logic                ssStart;
    logic [7:0]          rxByte;
    logic                rxByteValid;
    logic [AddrBits-1:0] rcMemAddr;
    logic [7:0]          rcMemData;
    logic                rcMemWE;
    logic                txAddrReset;
    logic [AddrBits-1:0] txLen;
    logic [7:0]          statusByte;
    logic                busy;

    modport master (
        output ssStart, rxByte, rxByteValid,
        input  rcMemAddr, rcMemData, rcMemWE, txAddrReset, txLen, statusByte, busy
    );

    modport slave (
        input  ssStart, rxByte, rxByteValid,
        output rcMemAddr, rcMemData, rcMemWE, txAddrReset, txLen, statusByte, busy
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: command byte, 4-byte big-endian size, then payload.
// PUT payload goes to the receive memory, GET arms the tx path, GET_STATUS clears sticky flags.
//
// state      | meaning
// -----------+--------------------------------------------
// ST_CMD     | next valid byte is a command
// ST_SIZE    | collecting 4 size bytes, MSB first
// ST_PAYLOAD | counting payload bytes (written for PUT)
// ST_IGNORE  | dropping bytes until the next ssStart
module spi_cmd_ctrl #(
    parameter int AddrBits = 12
) (
    input  logic          SysClk,
    input  logic          Reset_n,
    spi_cmd_ctrl_if.slave bus
);

    typedef enum logic [1:0] {ST_CMD, ST_SIZE, ST_PAYLOAD, ST_IGNORE} state_t;
    typedef enum logic {MODE_GET, MODE_PUT} mode_t;

    localparam logic [31:0] CAP            = 32'd1 << AddrBits;
    localparam logic [7:0]  CMD_GET_STATUS = 8'h00;
    localparam logic [7:0]  CMD_GET_BUFFER = 8'h01;
    localparam logic [7:0]  CMD_PUT_BUFFER = 8'h02;

    state_t              state_q;
    mode_t               mode_q;
    logic [31:0]         size_q;
    logic [1:0]          size_idx_q;
    logic [31:0]         byte_count_q;
    logic [AddrBits-1:0] rc_mem_addr_q;
    logic [7:0]          rc_mem_data_q;
    logic                rc_mem_we_q;
    logic                tx_addr_reset_q;
    logic [AddrBits-1:0] tx_len_q;
    logic                overflow_q;
    logic                bad_cmd_q;
    logic                put_done_q;
    logic                busy_q;

    state_t      dec_state;
    logic [31:0] size_d;
    logic [31:0] byte_count_d;
    logic        last_byte;

    // ssStart aborts first, so a byte arriving in the same cycle is decoded as a command
    assign dec_state    = bus.ssStart ? ST_CMD : state_q;
    assign size_d       = {size_q[23:0], bus.rxByte};
    assign byte_count_d = byte_count_q + 32'd1;
    assign last_byte    = (byte_count_q == (size_q - 32'd1));

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= ST_CMD;
            mode_q          <= MODE_GET;
            size_q          <= '0;
            size_idx_q      <= '0;
            byte_count_q    <= '0;
            rc_mem_addr_q   <= '0;
            rc_mem_data_q   <= '0;
            rc_mem_we_q     <= 1'b0;
            tx_addr_reset_q <= 1'b0;
            tx_len_q        <= '0;
            overflow_q      <= 1'b0;
            bad_cmd_q       <= 1'b0;
            put_done_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            rc_mem_we_q     <= 1'b0;
            tx_addr_reset_q <= 1'b0;

            if (bus.ssStart) begin
                state_q      <= ST_CMD;
                size_idx_q   <= '0;
                byte_count_q <= '0;
                busy_q       <= 1'b0;
            end

            if (bus.rxByteValid) begin
                case (dec_state)
                    ST_CMD: begin
                        case (bus.rxByte)
                            CMD_GET_STATUS: begin
                                bad_cmd_q  <= 1'b0;
                                overflow_q <= 1'b0;
                            end
                            CMD_GET_BUFFER: begin
                                mode_q     <= MODE_GET;
                                size_idx_q <= '0;
                                state_q    <= ST_SIZE;
                                busy_q     <= 1'b1;
                            end
                            CMD_PUT_BUFFER: begin
                                mode_q     <= MODE_PUT;
                                size_idx_q <= '0;
                                put_done_q <= 1'b0;
                                state_q    <= ST_SIZE;
                                busy_q     <= 1'b1;
                            end
                            default: begin
                                bad_cmd_q <= 1'b1;
                                state_q   <= ST_IGNORE;
                                busy_q    <= 1'b0;
                            end
                        endcase
                    end

                    ST_SIZE: begin
                        size_q     <= size_d;
                        size_idx_q <= size_idx_q + 2'd1;
                        if (size_idx_q == 2'd3) begin
                            if (size_d == 32'd0) begin
                                state_q <= ST_CMD;
                                busy_q  <= 1'b0;
                                if (mode_q == MODE_GET) begin
                                    tx_addr_reset_q <= 1'b1;
                                    tx_len_q        <= '0;
                                end
                            end else begin
                                if (size_d > CAP) begin
                                    overflow_q <= 1'b1;
                                end
                                // a length of exactly CAP truncates to 0 in AddrBits bits
                                if (mode_q == MODE_GET) begin
                                    tx_addr_reset_q <= 1'b1;
                                    tx_len_q        <= (size_d > CAP) ? '0 : size_d[AddrBits-1:0];
                                end
                                byte_count_q <= '0;
                                state_q      <= ST_PAYLOAD;
                            end
                        end
                    end

                    ST_PAYLOAD: begin
                        if ((mode_q == MODE_PUT) && (byte_count_q < CAP)) begin
                            rc_mem_we_q   <= 1'b1;
                            rc_mem_data_q <= bus.rxByte;
                            rc_mem_addr_q <= byte_count_q[AddrBits-1:0];
                        end
                        byte_count_q <= byte_count_d;
                        if (last_byte) begin
                            state_q <= ST_CMD;
                            busy_q  <= 1'b0;
                            if (mode_q == MODE_PUT) begin
                                put_done_q <= 1'b1;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.rcMemAddr   = rc_mem_addr_q;
    assign bus.rcMemData   = rc_mem_data_q;
    assign bus.rcMemWE     = rc_mem_we_q;
    assign bus.txAddrReset = tx_addr_reset_q;
    assign bus.txLen       = tx_len_q;
    assign bus.statusByte  = {overflow_q, bad_cmd_q, 4'b0000, put_done_q, busy_q};
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a 12-bit and a 4-bit instance see the same byte stream.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [11:0] wa12[$];
    logic [7:0]  wd12[$];
    logic [3:0]  wa4[$];
    logic [7:0]  wd4[$];
    int          ta12 = 0;

    spi_cmd_ctrl_if #(.AddrBits(12)) bus12();
    spi_cmd_ctrl_if #(.AddrBits(4))  bus4();

    assign bus12.ssStart     = ss;
    assign bus12.rxByte      = rx_byte;
    assign bus12.rxByteValid = rx_valid;
    assign bus4.ssStart      = ss;
    assign bus4.rxByte       = rx_byte;
    assign bus4.rxByteValid  = rx_valid;

    spi_cmd_ctrl #(.AddrBits(12)) dut12 (.SysClk(clk), .Reset_n(rst_n), .bus(bus12));
    spi_cmd_ctrl #(.AddrBits(4))  dut4  (.SysClk(clk), .Reset_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus12.rcMemWE === 1'b1) begin
            wa12.push_back(bus12.rcMemAddr);
            wd12.push_back(bus12.rcMemData);
        end
        if (bus4.rcMemWE === 1'b1) begin
            wa4.push_back(bus4.rcMemAddr);
            wd4.push_back(bus4.rcMemData);
        end
        if (bus12.txAddrReset === 1'b1) ta12++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_ss();
        @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
        #1;
    endtask

    task automatic clear_logs();
        wa12.delete();
        wd12.delete();
        wa4.delete();
        wd4.delete();
        ta12 = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus12.statusByte !== 8'h00) begin errors++; $display("FAIL reset_status12: got %h want %h", bus12.statusByte, 8'h00); end
        checks++; if (bus12.rcMemWE !== 1'b0 || bus12.txAddrReset !== 1'b0 || bus12.busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl12: got we=%b tr=%b busy=%b want 0 0 0", bus12.rcMemWE, bus12.txAddrReset, bus12.busy); end
        checks++; if (bus12.txLen !== 12'h000 || bus12.rcMemAddr !== 12'h000 || bus12.rcMemData !== 8'h00) begin errors++; $display("FAIL reset_data12: got len=%h addr=%h data=%h want 0", bus12.txLen, bus12.rcMemAddr, bus12.rcMemData); end
        checks++; if (bus4.statusByte !== 8'h00 || bus4.txLen !== 4'h0) begin errors++; $display("FAIL reset_4: got status=%h len=%h want 00 0", bus4.statusByte, bus4.txLen); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_put3();
        logic [7:0] data[3];
        data[0] = 8'hAA; data[1] = 8'hBB; data[2] = 8'hCC;
        clear_logs();
        pulse_ss();
        send_byte(8'h02);
        checks++; if (bus12.busy !== 1'b1) begin errors++; $display("FAIL put3_busy_size: got %b want 1", bus12.busy); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i]);
            checks++;
            if (bus12.rcMemWE !== 1'b1 || bus12.rcMemAddr !== 12'(i) || bus12.rcMemData !== data[i]) begin
                errors++;
                $display("FAIL put3_write%0d: got we=%b addr=%h data=%h want 1 %h %h", i, bus12.rcMemWE, bus12.rcMemAddr, bus12.rcMemData, 12'(i), data[i]);
            end
        end
        checks++; if (bus12.statusByte !== 8'h02) begin errors++; $display("FAIL put3_status: got %h want 02", bus12.statusByte); end
        @(negedge clk); #1;
        checks++; if (bus12.rcMemWE !== 1'b0) begin errors++; $display("FAIL put3_we_low: got %b want 0", bus12.rcMemWE); end
        checks++; if (wa12.size() !== 3) begin errors++; $display("FAIL put3_count: got %0d want 3", wa12.size()); end
    endtask

    task automatic test_get();
        clear_logs();
        pulse_ss();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        checks++; if (bus12.txAddrReset !== 1'b1) begin errors++; $display("FAIL get_addr_reset: got %b want 1", bus12.txAddrReset); end
        checks++; if (bus12.txLen !== 12'd16) begin errors++; $display("FAIL get_txlen12: got %0d want 16", bus12.txLen); end
        checks++; if (bus4.txLen !== 4'd0 || bus4.statusByte[7] !== 1'b0) begin errors++; $display("FAIL get_txlen4: got len=%0d ovf=%b want 0 0", bus4.txLen, bus4.statusByte[7]); end
        for (int i = 0; i < 15; i++) send_byte(8'h5A);
        checks++; if (bus12.busy !== 1'b1) begin errors++; $display("FAIL get_busy15: got %b want 1", bus12.busy); end
        send_byte(8'h5A);
        checks++; if (bus12.busy !== 1'b0) begin errors++; $display("FAIL get_busy16: got %b want 0", bus12.busy); end
        @(negedge clk); #1;
        checks++; if (wa12.size() !== 0) begin errors++; $display("FAIL get_no_writes: got %0d want 0", wa12.size()); end
        checks++; if (ta12 !== 1) begin errors++; $display("FAIL get_pulse_count: got %0d want 1", ta12); end
    endtask

    task automatic test_overflow();
        clear_logs();
        pulse_ss();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        checks++; if (bus4.statusByte[7] !== 1'b1 || bus12.statusByte[7] !== 1'b0) begin errors++; $display("FAIL ovf_flag: got ovf4=%b ovf12=%b want 1 0", bus4.statusByte[7], bus12.statusByte[7]); end
        for (int i = 0; i < 32; i++) send_byte(8'h80 + 8'(i));
        @(negedge clk); #1;
        checks++; if (wa4.size() !== 16) begin errors++; $display("FAIL ovf_count4: got %0d want 16", wa4.size()); end
        for (int i = 0; i < wa4.size() && i < 16; i++) begin
            checks++;
            if (wa4[i] !== 4'(i) || wd4[i] !== (8'h80 + 8'(i))) begin
                errors++;
                $display("FAIL ovf_write%0d: got addr=%h data=%h want %h %h", i, wa4[i], wd4[i], 4'(i), 8'h80 + 8'(i));
            end
        end
        checks++; if (wa12.size() !== 32) begin errors++; $display("FAIL ovf_count12: got %0d want 32", wa12.size()); end
        checks++; if (bus4.statusByte !== 8'h82) begin errors++; $display("FAIL ovf_status4: got %h want 82", bus4.statusByte); end
        checks++; if (bus12.statusByte !== 8'h02) begin errors++; $display("FAIL ovf_status12: got %h want 02", bus12.statusByte); end
    endtask

    task automatic test_badcmd();
        pulse_ss();
        send_byte(8'h07);
        checks++; if (bus12.statusByte !== 8'h42) begin errors++; $display("FAIL bad_status12: got %h want 42", bus12.statusByte); end
        checks++; if (bus4.statusByte !== 8'hC2) begin errors++; $display("FAIL bad_status4: got %h want c2", bus4.statusByte); end
        send_byte(8'h02); send_byte(8'h00);
        checks++; if (bus12.busy !== 1'b0) begin errors++; $display("FAIL bad_ignored: got busy=%b want 0", bus12.busy); end
        pulse_ss();
        @(negedge clk);
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        #1;
        checks++; if (bus12.statusByte[6] !== 1'b1 || bus4.statusByte[7] !== 1'b1) begin errors++; $display("FAIL status_visible: got bad=%b ovf4=%b want 1 1", bus12.statusByte[6], bus4.statusByte[7]); end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        checks++; if (bus12.statusByte !== 8'h02) begin errors++; $display("FAIL status_cleared12: got %h want 02", bus12.statusByte); end
        checks++; if (bus4.statusByte !== 8'h02) begin errors++; $display("FAIL status_cleared4: got %h want 02", bus4.statusByte); end
    endtask

    task automatic test_abort();
        clear_logs();
        pulse_ss();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        pulse_ss();
        checks++; if (bus12.statusByte !== 8'h00) begin errors++; $display("FAIL abort_status: got %h want 00", bus12.statusByte); end
        checks++; if (wa12.size() !== 3) begin errors++; $display("FAIL abort_count: got %0d want 3", wa12.size()); end
        send_byte(8'h02);
        checks++; if (bus12.busy !== 1'b1) begin errors++; $display("FAIL abort_new_cmd: got busy=%b want 1", bus12.busy); end
        pulse_ss();
    endtask

    task automatic test_simultaneous();
        clear_logs();
        pulse_ss();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'hDD);
        @(negedge clk);
        ss       = 1'b1;
        rx_byte  = 8'h02;
        rx_valid = 1'b1;
        @(negedge clk);
        ss       = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++; if (bus12.busy !== 1'b1 || bus12.rcMemWE !== 1'b0) begin errors++; $display("FAIL simul_state: got busy=%b we=%b want 1 0", bus12.busy, bus12.rcMemWE); end
        checks++; if (wa12.size() !== 1) begin errors++; $display("FAIL simul_count: got %0d want 1", wa12.size()); end
        send_byte(8'h00); send_byte(8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus12.statusByte !== 8'h00 || bus12.busy !== 1'b0) begin errors++; $display("FAIL async_status: got %h busy=%b want 00 0", bus12.statusByte, bus12.busy); end
        checks++; if (bus12.rcMemData !== 8'h00 || bus12.rcMemAddr !== 12'h000 || bus12.rcMemWE !== 1'b0) begin errors++; $display("FAIL async_mem: got addr=%h data=%h we=%b want 0", bus12.rcMemAddr, bus12.rcMemData, bus12.rcMemWE); end
        checks++; if (bus12.txLen !== 12'h000 || bus12.txAddrReset !== 1'b0) begin errors++; $display("FAIL async_tx: got len=%h tr=%b want 0 0", bus12.txLen, bus12.txAddrReset); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hEE);
        checks++; if (bus12.rcMemWE !== 1'b1 || bus12.rcMemAddr !== 12'h000 || bus12.rcMemData !== 8'hEE) begin errors++; $display("FAIL noss_write: got we=%b addr=%h data=%h want 1 000 ee", bus12.rcMemWE, bus12.rcMemAddr, bus12.rcMemData); end
        checks++; if (bus12.statusByte !== 8'h02) begin errors++; $display("FAIL noss_status: got %h want 02", bus12.statusByte); end
    endtask

    task automatic test_get_zero();
        clear_logs();
        pulse_ss();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        checks++; if (bus12.txLen !== 12'd5) begin errors++; $display("FAIL get5_txlen: got %0d want 5", bus12.txLen); end
        pulse_ss();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++; if (bus12.txAddrReset !== 1'b1 || bus12.txLen !== 12'd0) begin errors++; $display("FAIL get0_tx: got tr=%b len=%0d want 1 0", bus12.txAddrReset, bus12.txLen); end
        checks++; if (bus12.busy !== 1'b0) begin errors++; $display("FAIL get0_busy: got %b want 0", bus12.busy); end
        @(negedge clk); #1;
        checks++; if (ta12 !== 2) begin errors++; $display("FAIL get0_pulse_count: got %0d want 2", ta12); end
    endtask

    initial begin
        test_reset();
        test_put3();
        test_get();
        test_overflow();
        test_badcmd();
        test_abort();
        test_simultaneous();
        test_get_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- SysClk-domain command sequencer that sits behind the SPI byte receiver.
- Parses each SPI transaction as a command byte, then a 4-byte big-endian size, then the payload.
- PUT_BUFFER payload is written into the receive memory at sequential addresses.
- GET_BUFFER arms the transmit path with a length and an address reset. GET_STATUS exposes a status byte for the tx path to return.

Parameters:
- AddrBits, 12, width of rcMemAddr and txLen; buffer capacity is 2^AddrBits bytes.

Ports:
- SysClk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ssStart  in  1  one-cycle pulse: SPI_SS falling edge, already synchronized to SysClk.
- rxByte  in  8  received byte; valid only with rxByteValid.
- rxByteValid  in  1  one-cycle pulse per received byte (SysClk domain).
- rcMemAddr  out  AddrBits  receive-memory write address.
- rcMemData  out  8  receive-memory write data.
- rcMemWE  out  1  receive-memory write enable, one cycle per write.
- txAddrReset  out  1  one-cycle pulse: tx path restarts at address 0.
- txLen  out  AddrBits  number of bytes the tx path may send; held until the next GET_BUFFER.
- statusByte  out  8  {overflow, badCmd, 4'b0, putDone, busy}.
- busy  out  1  high while in SIZE or PAYLOAD.

Behaviour:
- Reset (Reset_n low, asynchronous): all outputs 0, state CMD, counters 0, sticky flags 0.
- States:
  - CMD: next byte is the command.
  - SIZE: collects 4 size bytes, MSB first.
  - PAYLOAD: counts payload bytes.
  - IGNORE: drops bytes until the next ssStart.
- CMD, on rxByteValid:
  - 0x00 GET_STATUS: stay in CMD.
  - 0x01 GET_BUFFER: mode=GET, sizeIdx=0, go to SIZE.
  - 0x02 PUT_BUFFER: mode=PUT, sizeIdx=0, go to SIZE.
  - Any other value: set badCmd, go to IGNORE.
- SIZE:
  - Each valid byte shifts into the 32-bit size register (size = {size[23:0], rxByte}).
  - On the 4th byte, evaluate the completed size S:
    - S == 0: go to CMD; for GET, pulse txAddrReset and set txLen=0.
    - S > 2^AddrBits: set overflow; effective length = 2^AddrBits.
    - GET: pulse txAddrReset on the cycle after the 4th byte; txLen = min(S, 2^AddrBits) truncated to AddrBits bits. Then go to PAYLOAD, where bytes are counted and discarded.
    - PUT: byteCount=0, go to PAYLOAD.
- PAYLOAD, on each valid byte:
  - PUT: if byteCount < 2^AddrBits, then on the next cycle rcMemWE=1, rcMemData=rxByte, rcMemAddr=byteCount[AddrBits-1:0]. Bytes beyond capacity are not written; no wrap-around.
  - byteCount is a 32-bit register that increments per byte.
  - When byteCount == S-1: go to CMD. For PUT, set putDone (sticky; cleared by the next PUT command byte).
- Write latency: rcMemWE is registered and asserted exactly 1 cycle after rxByteValid. It is never high for two consecutive cycles unless two consecutive rxByteValid pulses arrive.
- ssStart:
  - From any state, forces CMD and clears sizeIdx and byteCount. An in-progress PUT ends without setting putDone.
  - ssStart and rxByteValid in the same cycle: the abort is applied first, and that byte is decoded as a command byte.
- Sticky flags:
  - badCmd and overflow clear only on reset or when a GET_STATUS command byte is accepted. The flag values stay visible on statusByte during the cycle the clear takes effect; they read 0 from the next cycle.
- busy = (state==SIZE || state==PAYLOAD), registered.
- Bytes arriving with no preceding ssStart after reset are decoded from CMD.

Test Plan:
- PUT of 3 bytes: ssStart; bytes 02,00,00,00,03,AA,BB,CC -> writes (0,AA),(1,BB),(2,CC), each 1 cycle after its rxByteValid; putDone=1, busy=0, state CMD.
- GET, size 0x10: ssStart; bytes 01,00,00,00,10 -> one txAddrReset pulse, txLen=16. Then 16 dummy bytes -> no rcMemWE; back to CMD.
- Overflow, AddrBits=4: PUT with size 0x20 followed by 32 bytes -> 16 writes at addr 0..15, no wrap; statusByte[7]=1.
- Bad command then status: byte 07 -> badCmd=1, following bytes ignored. ssStart, then byte 00 -> statusByte[6] reads 1 that cycle, 0 afterwards.
- Abort mid-payload: PUT size 8, ssStart after 3 payload bytes -> exactly 3 writes, putDone=0. An immediate 02 command is accepted.
- Simultaneous: ssStart and rxByteValid (byte 02) in the same cycle while in PAYLOAD -> state SIZE. Async reset mid-SIZE -> all outputs 0 immediately, with no clock edge needed.
